// File: rtl/shift_row_pipe.sv
// -----------------------------------------------------------------------------
// shift_row_pipe
//   Registered, flow-controlled ShiftRows / InvShiftRows stage for the AES
//   (Rijndael) round datapath. The permutation is applied combinationally on
//   the input side. The result is then held in a two-register skid pipeline,
//   so upstream ready comes straight from a flop.
//
// Parameters
//   NB          state columns: 4, 6 or 8
//   DATA_WIDTH  state width in bits, always 32*NB (derived, do not override)
//
// Ports
//   clk                     rising-edge clock
//   rst_n                   synchronous reset, active low
//   shiftRowPipe_valid_in   input beat valid
//   shiftRowPipe_ready_in   block can accept a beat this cycle (registered)
//   shiftRowPipe_inv_in     0 = ShiftRows, 1 = InvShiftRows (per beat)
//   shiftRowPipe_data_in    state in, column-major, byte 0 in the MSBs
//   shiftRowPipe_valid_out  output beat valid
//   shiftRowPipe_ready_out  downstream accepts a beat this cycle
//   shiftRowPipe_data_out   shifted state, all zeros while not valid
// -----------------------------------------------------------------------------
module shift_row_pipe #(
    parameter int unsigned NB         = 4,
    parameter int unsigned DATA_WIDTH = 32 * NB
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shiftRowPipe_valid_in,
    output logic                  shiftRowPipe_ready_in,
    input  logic                  shiftRowPipe_inv_in,
    input  logic [DATA_WIDTH-1:0] shiftRowPipe_data_in,
    output logic                  shiftRowPipe_valid_out,
    input  logic                  shiftRowPipe_ready_out,
    output logic [DATA_WIDTH-1:0] shiftRowPipe_data_out
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_row_pipe: NB must be 4, 6 or 8");
    end

    if (DATA_WIDTH != 32 * NB) begin : g_bad_width
        $error("shift_row_pipe: DATA_WIDTH must equal 32*NB");
    end

    // -------------------------------------------------------------------------
    // Row rotation amounts: 256-bit blocks use {0,1,3,4}, narrower use {0,1,2,3}
    // -------------------------------------------------------------------------
    function automatic int unsigned row_offset(input int unsigned r);
        int unsigned s;
        s = r;
        if (NB == 8) begin
            case (r)
                0:       s = 0;
                1:       s = 1;
                2:       s = 3;
                default: s = 4;
            endcase
        end
        return s;
    endfunction

    // Byte k = 4*c + r lives at data[DATA_WIDTH-1-8k -: 8].
    // Encrypt reads column (c + s) mod NB. Decrypt reads (c - s) mod NB,
    // which is written as (c + NB - s) so the unsigned arithmetic never wraps.
    function automatic logic [DATA_WIDTH-1:0] shift_state(
        input logic [DATA_WIDTH-1:0] d,
        input logic                  inv
    );
        logic [DATA_WIDTH-1:0] o;
        int unsigned           src_c;
        o = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (inv)
                    src_c = (c + NB - row_offset(r)) % NB;
                else
                    src_c = (c + row_offset(r)) % NB;
                o[DATA_WIDTH-1-8*(4*c+r) -: 8] = d[DATA_WIDTH-1-8*(4*src_c+r) -: 8];
            end
        end
        return o;
    endfunction

    // -------------------------------------------------------------------------
    // Storage: main register M drives the outputs; skid register S catches
    // the one beat that can arrive while M is stalled.
    // -------------------------------------------------------------------------
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  ready_q;

    logic [DATA_WIDTH-1:0] shifted;
    logic                  accept;
    logic                  m_free;
    logic                  s_valid_next;

    always_comb begin
        shifted = shift_state(shiftRowPipe_data_in, shiftRowPipe_inv_in);
        accept  = shiftRowPipe_valid_in & ready_q;
        // M can take a new value when it is empty or is being drained now.
        m_free  = ~m_valid | shiftRowPipe_ready_out;
        // When M is free, S either moves into M or was already empty.
        // An accept with S full cannot happen because ready_q is low then.
        if (m_free)
            s_valid_next = 1'b0;
        else
            s_valid_next = s_valid | accept;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            ready_q <= 1'b0;
        end else begin
            if (m_free) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= s_data;
                    s_data  <= '0;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_data  <= shifted;
                end else begin
                    // Clearing the data keeps data_out at zero while idle.
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end
            end else if (accept) begin
                s_data <= shifted;
            end
            s_valid <= s_valid_next;
            // Ready tracks "S will be empty", so upstream never sees a
            // combinational path from downstream ready.
            ready_q <= ~s_valid_next;
        end
    end

    assign shiftRowPipe_ready_in  = ready_q;
    assign shiftRowPipe_valid_out = m_valid;
    assign shiftRowPipe_data_out  = m_data;

endmodule

// File: tb/tb_shift_row_pipe.sv
module tb_shift_row_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // NB = 4 instance
    logic         v4, rdy4, inv4, vo4, ro4;
    logic [127:0] d4, do4;
    // NB = 6 instance
    logic         v6, rdy6, inv6, vo6, ro6;
    logic [191:0] d6, do6;
    // NB = 8 instance
    logic         v8, rdy8, inv8, vo8, ro8;
    logic [255:0] d8, do8;

    shift_row_pipe #(.NB(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .shiftRowPipe_valid_in(v4), .shiftRowPipe_ready_in(rdy4),
        .shiftRowPipe_inv_in(inv4), .shiftRowPipe_data_in(d4),
        .shiftRowPipe_valid_out(vo4), .shiftRowPipe_ready_out(ro4),
        .shiftRowPipe_data_out(do4)
    );

    shift_row_pipe #(.NB(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .shiftRowPipe_valid_in(v6), .shiftRowPipe_ready_in(rdy6),
        .shiftRowPipe_inv_in(inv6), .shiftRowPipe_data_in(d6),
        .shiftRowPipe_valid_out(vo6), .shiftRowPipe_ready_out(ro6),
        .shiftRowPipe_data_out(do6)
    );

    shift_row_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .shiftRowPipe_valid_in(v8), .shiftRowPipe_ready_in(rdy8),
        .shiftRowPipe_inv_in(inv8), .shiftRowPipe_data_in(d8),
        .shiftRowPipe_valid_out(vo8), .shiftRowPipe_ready_out(ro8),
        .shiftRowPipe_data_out(do8)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] SEQ4     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ4_ENC = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] SEQ4_DEC = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [191:0] SEQ6     = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] SEQ6_ENC = 192'h00050a0f04090e13080d12170c11160310150207140106_0b;
    localparam logic [255:0] SEQ8     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] SEQ8_ENC = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; inv4 = 1'b0; d4 = '0; ro4 = 1'b1;
        v6 = 1'b0; inv6 = 1'b0; d6 = '0; ro6 = 1'b1;
        v8 = 1'b0; inv8 = 1'b0; d8 = '0; ro8 = 1'b1;

        // Reset state
        step(); step();
        check("reset_valid4", {255'd0, vo4}, 256'd0);
        check("reset_data4", {128'd0, do4}, 256'd0);
        check("reset_ready4", {255'd0, rdy4}, 256'd0);
        check("reset_ready8", {255'd0, rdy8}, 256'd0);
        rst_n = 1'b1;
        step();
        check("ready_after_reset4", {255'd0, rdy4}, 256'd1);

        // FIPS-197 vector, encrypt, then decrypt, back-to-back
        v4 = 1'b1; inv4 = 1'b0; d4 = FIPS_IN;
        step();
        check("fips_enc_valid", {255'd0, vo4}, 256'd1);
        check("fips_enc_data", {128'd0, do4}, {128'd0, FIPS_OUT});
        inv4 = 1'b1; d4 = FIPS_OUT;
        step();
        check("fips_dec_data", {128'd0, do4}, {128'd0, FIPS_IN});

        // Alternating modes on the same data, one beat per cycle
        inv4 = 1'b0; d4 = SEQ4;
        step();
        check("seq4_enc", {128'd0, do4}, {128'd0, SEQ4_ENC});
        inv4 = 1'b1;
        step();
        check("seq4_dec", {128'd0, do4}, {128'd0, SEQ4_DEC});
        inv4 = 1'b0;
        step();
        check("seq4_enc_again", {128'd0, do4}, {128'd0, SEQ4_ENC});
        v4 = 1'b0;
        step();
        check("idle_valid4", {255'd0, vo4}, 256'd0);
        check("idle_data4", {128'd0, do4}, 256'd0);

        // Wider blocks: NB=8 encrypt then decrypt of the result; NB=6 encrypt
        v8 = 1'b1; inv8 = 1'b0; d8 = SEQ8;
        v6 = 1'b1; inv6 = 1'b0; d6 = SEQ6;
        step();
        check("nb8_first_word", {224'd0, do8[255:224]}, {224'd0, 32'h00050e13});
        check("nb8_enc", do8, SEQ8_ENC);
        check("nb6_enc", {64'd0, do6}, {64'd0, SEQ6_ENC});
        inv8 = 1'b1; d8 = SEQ8_ENC;
        v6 = 1'b0;
        step();
        check("nb8_roundtrip", do8, SEQ8);
        check("nb6_idle", {255'd0, vo6}, 256'd0);
        v8 = 1'b0;
        step();
        check("nb8_idle", {255'd0, vo8}, 256'd0);

        // Backpressure: three beats offered against a stalled output
        ro4 = 1'b0;
        v4 = 1'b1; inv4 = 1'b0; d4 = FIPS_IN;      // beat A
        step();
        check("bp_a_out", {128'd0, do4}, {128'd0, FIPS_OUT});
        check("bp_ready_after_a", {255'd0, rdy4}, 256'd1);
        d4 = SEQ4;                                  // beat B -> skid
        step();
        check("bp_ready_after_b", {255'd0, rdy4}, 256'd0);
        check("bp_hold_1", {128'd0, do4}, {128'd0, FIPS_OUT});
        inv4 = 1'b1; d4 = FIPS_OUT;                 // beat C, must wait
        step();
        check("bp_hold_2", {128'd0, do4}, {128'd0, FIPS_OUT});
        check("bp_hold_valid", {255'd0, vo4}, 256'd1);
        check("bp_ready_still_low", {255'd0, rdy4}, 256'd0);
        ro4 = 1'b1;
        step();
        check("bp_release_b", {128'd0, do4}, {128'd0, SEQ4_ENC});
        check("bp_ready_back", {255'd0, rdy4}, 256'd1);
        step();
        check("bp_release_c", {128'd0, do4}, {128'd0, FIPS_IN});
        v4 = 1'b0;
        step();
        check("bp_drained", {255'd0, vo4}, 256'd0);

        // Reset while two beats are held
        ro4 = 1'b0;
        v4 = 1'b1; inv4 = 1'b0; d4 = FIPS_IN;
        step();
        d4 = SEQ4;
        step();
        check("rst_full_ready", {255'd0, rdy4}, 256'd0);
        v4 = 1'b0;
        rst_n = 1'b0;
        step();
        check("rst_mid_valid", {255'd0, vo4}, 256'd0);
        check("rst_mid_data", {128'd0, do4}, 256'd0);
        check("rst_mid_ready", {255'd0, rdy4}, 256'd0);
        rst_n = 1'b1;
        ro4 = 1'b1;
        step();
        check("rst_after_ready", {255'd0, rdy4}, 256'd1);
        check("rst_after_valid", {255'd0, vo4}, 256'd0);
        step();
        check("rst_no_stale", {255'd0, vo4}, 256'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
